// File: rtl/frame_draw_sequencer.sv
// Per-frame sequencer for the breakout datapath: erases, moves and redraws the paddle,
// then the ball, one pixel per clock. It is the only writer to the VGA plot port.
module frame_draw_sequencer #(
  parameter int unsigned PADDLE_HALF  = 40,
  parameter int unsigned PADDLE_H     = 4,
  parameter int unsigned PADDLE_Y     = 440,
  parameter int unsigned PADDLE_RST_X = 320,
  parameter int unsigned BALL_SZ      = 4,
  parameter int unsigned BALL_RST_X   = 318,
  parameter int unsigned BALL_RST_Y   = 238,
  parameter logic [2:0]  BG_COL       = 3'b000,
  parameter logic [2:0]  PADDLE_COL   = 3'b111,
  parameter logic [2:0]  BALL_COL     = 3'b110
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       frame_tick_i,
  input  logic [9:0] paddle_x_i,
  input  logic [9:0] ball_x_i,
  input  logic [8:0] ball_y_i,
  output logic       paddle_en_o,
  output logic       ball_en_o,
  output logic [9:0] vga_x_o,
  output logic [8:0] vga_y_o,
  output logic [2:0] vga_colour_o,
  output logic       vga_plot_o,
  output logic       busy_o,
  output logic       frame_overrun_o
);

  localparam int unsigned PW = 2 * PADDLE_HALF;

  typedef enum logic [3:0] {
    IDLE, ERASE_P, MOVE_P, LATCH_P, DRAW_P, ERASE_B, MOVE_B, LATCH_B, DRAW_B
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cx_q, cx_d, cy_q, cy_d;
  logic [9:0]  old_px_q, old_px_d, old_bx_q, old_bx_d;
  logic [8:0]  old_by_q, old_by_d;
  logic        overrun_q, overrun_d;
  logic [9:0]  vga_x_q;
  logic [8:0]  vga_y_q;
  logic [2:0]  vga_col_q;
  logic        vga_plot_q;

  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic [2:0]  pix_col;
  logic        pix_active, pix_visible, paddle_phase;
  logic [7:0]  last_cx, last_cy;

  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    old_px_d   = old_px_q;
    old_bx_d   = old_bx_q;
    old_by_d   = old_by_q;
    overrun_d  = overrun_q | (frame_tick_i && (state_q != IDLE));
    pix_x      = '0;
    pix_y      = '0;
    pix_col    = BG_COL;
    pix_active = 1'b0;

    paddle_phase = (state_q == ERASE_P) || (state_q == DRAW_P);
    last_cx      = paddle_phase ? 8'(PW - 1) : 8'(BALL_SZ - 1);
    last_cy      = paddle_phase ? 8'(PADDLE_H - 1) : 8'(BALL_SZ - 1);

    case (state_q)
      IDLE: begin
        if (frame_tick_i) begin
          state_d = ERASE_P;
          cx_d    = '0;
          cy_d    = '0;
        end
      end
      ERASE_P, DRAW_P: begin
        pix_active = 1'b1;
        pix_x      = {1'b0, old_px_q} - 11'(PADDLE_HALF) + 11'(cx_q);
        pix_y      = 10'(PADDLE_Y) + 10'(cy_q);
        pix_col    = (state_q == ERASE_P) ? BG_COL : PADDLE_COL;
      end
      MOVE_P: state_d = LATCH_P;
      LATCH_P: begin
        old_px_d = paddle_x_i;
        state_d  = DRAW_P;
      end
      ERASE_B, DRAW_B: begin
        pix_active = 1'b1;
        pix_x      = {1'b0, old_bx_q} + 11'(cx_q);
        pix_y      = {1'b0, old_by_q} + 10'(cy_q);
        pix_col    = (state_q == ERASE_B) ? BG_COL : BALL_COL;
      end
      MOVE_B: state_d = LATCH_B;
      LATCH_B: begin
        old_bx_d = ball_x_i;
        old_by_d = ball_y_i;
        state_d  = DRAW_B;
      end
      default: state_d = IDLE;
    endcase

    // Row-major scan; the rectangle's last pixel hands over to the next phase.
    if (pix_active) begin
      if (cx_q == last_cx) begin
        cx_d = '0;
        if (cy_q == last_cy) begin
          cy_d = '0;
          case (state_q)
            ERASE_P: state_d = MOVE_P;
            DRAW_P:  state_d = ERASE_B;
            ERASE_B: state_d = MOVE_B;
            default: state_d = IDLE;
          endcase
        end else begin
          cy_d = cy_q + 8'd1;
        end
      end else begin
        cx_d = cx_q + 8'd1;
      end
    end

    // Bit 10 set means the paddle's left edge underflowed below column 0.
    pix_visible = pix_active && !pix_x[10] && (pix_x[9:0] < 10'd640) && (pix_y < 10'd480);
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      old_px_q   <= 10'(PADDLE_RST_X);
      old_bx_q   <= 10'(BALL_RST_X);
      old_by_q   <= 9'(BALL_RST_Y);
      overrun_q  <= 1'b0;
      vga_x_q    <= '0;
      vga_y_q    <= '0;
      vga_col_q  <= '0;
      vga_plot_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      old_px_q   <= old_px_d;
      old_bx_q   <= old_bx_d;
      old_by_q   <= old_by_d;
      overrun_q  <= overrun_d;
      vga_plot_q <= pix_visible;
      if (pix_active) begin
        vga_x_q   <= pix_x[9:0];
        vga_y_q   <= pix_y[8:0];
        vga_col_q <= pix_col;
      end
    end
  end

  assign paddle_en_o     = (state_q == MOVE_P);
  assign ball_en_o       = (state_q == MOVE_B);
  assign busy_o          = (state_q != IDLE);
  assign frame_overrun_o = overrun_q;
  assign vga_x_o         = vga_x_q;
  assign vga_y_o         = vga_y_q;
  assign vga_colour_o    = vga_col_q;
  assign vga_plot_o      = vga_plot_q;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Self-checking bench for frame_draw_sequencer: table vectors, reset/overrun sequences and
// randomised frames, all compared against a rectangle-list model of what each frame plots.
module tb_frame_draw_sequencer;

  logic       clk_i = 1'b0;
  logic       resetn_i;
  logic       frame_tick_i;
  logic [9:0] paddle_x_i;
  logic [9:0] ball_x_i;
  logic [8:0] ball_y_i;
  logic       paddle_en_o, ball_en_o, vga_plot_o, busy_o, frame_overrun_o;
  logic [9:0] vga_x_o;
  logic [8:0] vga_y_o;
  logic [2:0] vga_colour_o;

  frame_draw_sequencer dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .frame_tick_i(frame_tick_i),
    .paddle_x_i(paddle_x_i), .ball_x_i(ball_x_i), .ball_y_i(ball_y_i),
    .paddle_en_o(paddle_en_o), .ball_en_o(ball_en_o),
    .vga_x_o(vga_x_o), .vga_y_o(vga_y_o), .vga_colour_o(vga_colour_o),
    .vga_plot_o(vga_plot_o), .busy_o(busy_o), .frame_overrun_o(frame_overrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int x; int y; int col; } pix_t;
  typedef struct {
    int pNext; int bxNext; int byNext; int extraTickAt;
    int expBusy; int expPEn; int expBEn; int expOverrun; string name;
  } vec_t;

  pix_t  gotQ[$];
  pix_t  expQ[$];
  vec_t  vecs[6];
  int    vecCount = 0;
  int    missCount = 0;
  int    busyCnt, pEnCnt, bEnCnt, pEnCyc, bEnCyc;
  int    mPx, mBx, mBy;
  int    pTotal, bTotal;

  task automatic checkOutput(input string name, input int got, input int exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic addRect(input int x0, input int y0, input int w, input int h, input int col);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (x0 + c >= 0 && x0 + c < 640 && y0 + r < 480)
          expQ.push_back('{x0 + c, y0 + r, col});
  endtask

  // A frame plots: old paddle in background, new paddle, old ball in background, new ball.
  task automatic buildFrame(input int pNext, input int bx, input int by);
    expQ.delete();
    addRect(mPx - 40, 440, 80, 4, 0);
    addRect(pNext - 40, 440, 80, 4, 7);
    addRect(mBx, mBy, 4, 4, 0);
    addRect(bx, by, 4, 4, 6);
    mPx = pNext;
    mBx = bx;
    mBy = by;
  endtask

  task automatic compareStream(input string name, input int limit);
    int lim;
    int bad;
    lim = (limit < 0) ? expQ.size() : limit;
    checkOutput({name, ".plotCount"}, gotQ.size(), lim);
    bad = -1;
    for (int i = 0; i < lim && i < gotQ.size(); i++)
      if (bad < 0 && gotQ[i] != expQ[i]) bad = i;
    vecCount++;
    if (bad >= 0) begin
      missCount++;
      $display("[TB] FAIL %s.stream pixel %0d got=(%0d,%0d,%0d) expected=(%0d,%0d,%0d)", name, bad,
               gotQ[bad].x, gotQ[bad].y, gotQ[bad].col, expQ[bad].x, expQ[bad].y, expQ[bad].col);
    end
  endtask

  // Issues one tick and runs the frame cycle by cycle, acting as both movers.
  task automatic applyStimulus(input int pNext, input int bxNext, input int byNext,
                               input int extraTickAt, input int resetAt, input int cycles);
    gotQ.delete();
    busyCnt = 0; pEnCnt = 0; bEnCnt = 0; pEnCyc = -1; bEnCyc = -1;
    paddle_x_i   = 10'($urandom);
    ball_x_i     = 10'($urandom);
    ball_y_i     = 9'($urandom);
    frame_tick_i = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_i);
      frame_tick_i = 1'b0;
      if (vga_plot_o) gotQ.push_back('{int'(vga_x_o), int'(vga_y_o), int'(vga_colour_o)});
      if (busy_o) busyCnt++;
      if (paddle_en_o) begin
        pEnCnt++; pEnCyc = c; paddle_x_i = 10'(pNext);
      end
      if (ball_en_o) begin
        bEnCnt++; bEnCyc = c; ball_x_i = 10'(bxNext); ball_y_i = 9'(byNext);
      end
      if (c == extraTickAt) frame_tick_i = 1'b1;
      if (c == resetAt) begin
        resetn_i = 1'b0;
        #1;
        checkOutput("asyncResetPlot", int'(vga_plot_o), 0);
        checkOutput("asyncResetBusy", int'(busy_o), 0);
      end
      if (resetAt >= 0 && c == resetAt + 3) resetn_i = 1'b1;
    end
  endtask

  initial begin
    vecs[0] = '{321, 100, 50, -1, 676, 1, 1, 0, "basicMove"};
    vecs[1] = '{321, 104, 54, -1, 676, 1, 1, 0, "ballStep"};
    vecs[2] = '{320, 638, 478, -1, 676, 1, 1, 0, "ballCorner"};
    vecs[3] = '{10, 0, 0, -1, 676, 1, 1, 0, "paddleLeftClip"};
    vecs[4] = '{620, 5, 479, -1, 676, 1, 1, 0, "paddleRightClip"};
    vecs[5] = '{300, 200, 200, 100, 676, 1, 1, 1, "overrunTick"};

    resetn_i = 1'b0; frame_tick_i = 1'b0;
    paddle_x_i = '0; ball_x_i = '0; ball_y_i = '0;
    mPx = 320; mBx = 318; mBy = 238;
    repeat (3) @(negedge clk_i);
    checkOutput("rst.plot", int'(vga_plot_o), 0);
    checkOutput("rst.paddleEn", int'(paddle_en_o), 0);
    checkOutput("rst.ballEn", int'(ball_en_o), 0);
    checkOutput("rst.busy", int'(busy_o), 0);
    checkOutput("rst.overrun", int'(frame_overrun_o), 0);
    checkOutput("rst.x", int'(vga_x_o), 0);
    checkOutput("rst.y", int'(vga_y_o), 0);
    checkOutput("rst.colour", int'(vga_colour_o), 0);
    resetn_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 6; i++) begin
      buildFrame(vecs[i].pNext, vecs[i].bxNext, vecs[i].byNext);
      applyStimulus(vecs[i].pNext, vecs[i].bxNext, vecs[i].byNext, vecs[i].extraTickAt, -1, 700);
      compareStream(vecs[i].name, -1);
      checkOutput({vecs[i].name, ".busyCycles"}, busyCnt, vecs[i].expBusy);
      checkOutput({vecs[i].name, ".paddleEnCount"}, pEnCnt, vecs[i].expPEn);
      checkOutput({vecs[i].name, ".ballEnCount"}, bEnCnt, vecs[i].expBEn);
      // Frame cycle 0 is the first busy cycle; 320 erase cycles precede MOVE_P.
      checkOutput({vecs[i].name, ".paddleEnCycle"}, pEnCyc, 320);
      // MOVE_B follows the 16th ERASE_B cycle: 320+2+320+16 = 658.
      checkOutput({vecs[i].name, ".ballEnCycle"}, bEnCyc, 658);
      checkOutput({vecs[i].name, ".overrun"}, int'(frame_overrun_o), vecs[i].expOverrun);
    end

    // Reset 200 cycles into a frame: only the first 200 erase pixels ever appear.
    buildFrame(333, 50, 60);
    applyStimulus(333, 50, 60, -1, 200, 700);
    compareStream("midFrameReset", 200);
    checkOutput("midFrameReset.overrunCleared", int'(frame_overrun_o), 0);
    checkOutput("midFrameReset.paddleEnCount", pEnCnt, 0);
    mPx = 320; mBx = 318; mBy = 238;

    pTotal = 0; bTotal = 0;
    for (int f = 0; f < 10; f++) begin
      int pn, bx, by;
      pn = int'($urandom_range(0, 700));
      bx = int'($urandom_range(0, 660));
      by = int'($urandom_range(0, 500));
      buildFrame(pn, bx, by);
      applyStimulus(pn, bx, by, -1, -1, 1000);
      if (f == 0)
        checkOutput("postReset.firstEraseX", (gotQ.size() > 0) ? gotQ[0].x : -1, 280);
      compareStream($sformatf("randFrame%0d", f), -1);
      checkOutput($sformatf("randFrame%0d.busyCycles", f), busyCnt, 676);
      pTotal += pEnCnt;
      bTotal += bEnCnt;
    end
    checkOutput("periodic.paddleEnTotal", pTotal, 10);
    checkOutput("periodic.ballEnTotal", bTotal, 10);
    checkOutput("periodic.overrun", int'(frame_overrun_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
